// File: rtl/sysbus_arbiter.sv
// Two-requester system bus arbiter: round-robin grant, one outstanding line
// transaction, response beats routed back to the owning requester.
module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  input  logic [63:0]               req0_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  req0_tag,
  output logic                      req0_ready,
  output logic                      resp0_valid,
  output logic [BUS_DATA_WIDTH-1:0] resp0_data,
  output logic                      resp0_last,
  input  logic                      resp0_ready,
  input  logic                      req1_valid,
  input  logic [63:0]               req1_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  req1_tag,
  output logic                      req1_ready,
  output logic                      resp1_valid,
  output logic [BUS_DATA_WIDTH-1:0] resp1_data,
  output logic                      resp1_last,
  input  logic                      resp1_ready,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_grant_q, last_grant_d;
  logic [BUS_DATA_WIDTH-1:0] bus_req_q, bus_req_d;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_q, bus_reqtag_d;
  logic [3:0]                beat_q, beat_d;

  logic grant_any, grant_sel, owner_ready, beat_xfer, last_beat, idle_grant;
  logic unused_resptag;

  assign unused_resptag = ^bus_resptag;

  // grant_sel: 1 selects requester 1; on a tie the one not granted last wins
  assign grant_any   = req0_valid | req1_valid;
  assign grant_sel   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign idle_grant  = (state_q == IDLE) & grant_any & ~reset;
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;
  assign beat_xfer   = (state_q == RESP) & bus_respcyc & owner_ready;
  assign last_beat   = (beat_q == 4'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    bus_req_d    = bus_req_q;
    bus_reqtag_d = bus_reqtag_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: if (grant_any) begin
        state_d      = REQ;
        owner_d      = grant_sel;
        last_grant_d = grant_sel;
        bus_req_d    = grant_sel ? BUS_DATA_WIDTH'(req1_addr) : BUS_DATA_WIDTH'(req0_addr);
        bus_reqtag_d = grant_sel ? req1_tag : req0_tag;
      end
      REQ: if (bus_reqack) begin
        state_d = RESP;
        beat_d  = '0;
      end
      RESP: if (beat_xfer) begin
        beat_d = beat_q + 4'd1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
      beat_q       <= beat_d;
    end
  end

  assign req0_ready  = idle_grant & ~grant_sel;
  assign req1_ready  = idle_grant & grant_sel;
  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_req_q;
  assign bus_reqtag  = bus_reqtag_q;
  assign bus_respack = beat_xfer;

  // Data fans out to both requesters; only the owner's valid/last qualify it
  assign resp0_data  = bus_resp;
  assign resp1_data  = bus_resp;
  assign resp0_valid = (state_q == RESP) & ~owner_q & bus_respcyc;
  assign resp1_valid = (state_q == RESP) &  owner_q & bus_respcyc;
  assign resp0_last  = (state_q == RESP) & ~owner_q & last_beat;
  assign resp1_last  = (state_q == RESP) &  owner_q & last_beat;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: grant, request hold, beat routing with
// stalls, round-robin order, reset abort and idle response filtering.
module tb_sysbus_arbiter;
  logic        clk = 0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_addr, req1_addr;
  logic [12:0] req0_tag, req1_tag;
  logic        resp0_valid, resp1_valid, resp0_last, resp1_last;
  logic        resp0_ready, resp1_ready;
  logic [63:0] resp0_data, resp1_data;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_last(resp0_last), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_last(resp1_last), .resp1_ready(resp1_ready),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    req0_tag = 0; req1_tag = 0; resp0_ready = 0; resp1_ready = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reqcyc"}, bus_reqcyc, 0);
    chk({tag, "_respack"}, bus_respack, 0);
    chk({tag, "_r0v"}, resp0_valid, 0);
    chk({tag, "_r1v"}, resp1_valid, 0);
    chk({tag, "_r0l"}, resp0_last, 0);
    chk({tag, "_r1l"}, resp1_last, 0);
  endtask

  // Present beats got..stop_at-1; owner accepts every cycle or alternating.
  task automatic beats(input int who, input bit toggle, input int stop_at);
    int got = 0;
    int cyc = 0;
    bit rdy = 1;
    bus_respcyc = 1;
    while (got < stop_at && cyc < 40) begin
      bus_resp = 64'hBEA7_0000 + 64'(got);
      resp0_ready = (who == 0) ? rdy : 1'b1;
      resp1_ready = (who == 1) ? rdy : 1'b1;
      #1;
      chk("own_valid", who ? resp1_valid : resp0_valid, 1);
      chk("other_valid", who ? resp0_valid : resp1_valid, 0);
      chk("own_data", who ? resp1_data : resp0_data, 64'hBEA7_0000 + 64'(got));
      chk("own_last", who ? resp1_last : resp0_last, got == 7);
      chk("respack", bus_respack, rdy);
      tick();
      if (rdy) got++;
      cyc++;
      if (toggle) rdy = !rdy;
    end
    if (cyc >= 40) chk("beat_timeout", 0, 1);
    if (stop_at == 8) begin
      bus_respcyc = 0; resp0_ready = 0; resp1_ready = 0;
    end
  endtask

  task automatic run_txn(input int exp_owner, input bit toggle, input logic [63:0] exp_addr,
                         input logic [12:0] exp_tag);
    #1;
    chk("grant0", req0_ready, exp_owner == 0);
    chk("grant1", req1_ready, exp_owner == 1);
    tick();
    chk("txn_reqcyc", bus_reqcyc, 1);
    chk("txn_addr", bus_req, exp_addr);
    chk("txn_tag", bus_reqtag, exp_tag);
    chk("no_ready_in_req", req0_ready | req1_ready, 0);
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    chk("txn_reqcyc_drop", bus_reqcyc, 0);
    beats(exp_owner, toggle, 8);
  endtask

  initial begin
    do_reset();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_tag", bus_reqtag, 0);
    chk("rst_ready", req0_ready | req1_ready, 0);
    chk_quiet("rst");

    // Response cycle while idle is ignored
    bus_respcyc = 1; resp0_ready = 1; resp1_ready = 1; bus_resp = 64'h55;
    #1;
    chk_quiet("idle_resp");
    tick();
    bus_respcyc = 0; resp0_ready = 0; resp1_ready = 0;

    // Single request, acked 5 cycles late
    req0_valid = 1; req0_addr = 64'h1000; req0_tag = 13'h1100;
    #1;
    chk("r0_ready_pulse", req0_ready, 1);
    chk("r1_ready_none", req1_ready, 0);
    tick();
    req0_valid = 0; req0_addr = 64'hDEAD; req0_tag = 13'h0BAD;
    for (int i = 0; i < 5; i++) begin
      chk("hold_reqcyc", bus_reqcyc, 1);
      chk("hold_addr", bus_req, 64'h1000);
      chk("hold_tag", bus_reqtag, 13'h1100);
      tick();
    end
    bus_reqack = 1;
    #1;
    chk("ack_cycle_reqcyc", bus_reqcyc, 1);
    tick();
    bus_reqack = 0;
    chk("post_ack_reqcyc", bus_reqcyc, 0);
    beats(0, 0, 8);
    chk_quiet("back_idle");

    // Requester 1 alone with a stalling consumer
    do_reset();
    req1_valid = 1; req1_addr = 64'h2000; req1_tag = 13'h0555;
    #1;
    chk("r1_alone_grant", req1_ready, 1);
    tick();
    req1_valid = 0;
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    beats(1, 1, 8);
    chk_quiet("stall_done");

    // Both held from reset: order 0,1,0,1
    do_reset();
    req0_valid = 1; req0_addr = 64'h1000; req0_tag = 13'h0010;
    req1_valid = 1; req1_addr = 64'h2000; req1_tag = 13'h0020;
    run_txn(0, 0, 64'h1000, 13'h0010);
    run_txn(1, 0, 64'h2000, 13'h0020);
    run_txn(0, 1, 64'h1000, 13'h0010);
    run_txn(1, 0, 64'h2000, 13'h0020);
    req0_valid = 0; req1_valid = 0;

    // Reset while beat 3 is on the bus
    do_reset();
    req0_valid = 1; req0_addr = 64'h3000; req0_tag = 13'h0033;
    tick();
    req0_valid = 0;
    bus_reqack = 1;
    tick();
    bus_reqack = 0;
    beats(0, 0, 3);
    bus_resp = 64'hBEA7_0003;
    reset = 1;
    #1;
    chk("rst_mid_ready", req0_ready | req1_ready, 0);
    tick();
    reset = 0;
    #1;
    chk_quiet("abort");
    chk("abort_bus_req", bus_req, 0);
    chk("abort_tag", bus_reqtag, 0);
    tick();
    chk_quiet("abort_later");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
